// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: limits, defaults and the
// config clamp. Configuration words are handled at a fixed 32-bit width here.
package clk_div_pkg;

  localparam int CLKDIV_MIN_PERIOD = 2;
  localparam int CLKDIV_MIN_HIGH   = 1;
  localparam int CLKDIV_CFG_W      = 32;

  localparam int unsigned CLKDIV_DEF_PERIOD = 50_000_000;
  localparam int unsigned CLKDIV_DEF_HIGH   = 25_000_000;

  typedef logic [CLKDIV_CFG_W-1:0] cfg_word_t;

  typedef struct packed {
    cfg_word_t period;
    cfg_word_t high;
  } clk_cfg_t;

  // The high time is limited to period-1 so every period has at least one low cycle.
  function automatic clk_cfg_t clamp_cfg(input cfg_word_t period, input cfg_word_t high);
    clk_cfg_t c;
    c.period = (period < cfg_word_t'(CLKDIV_MIN_PERIOD)) ? cfg_word_t'(CLKDIV_MIN_PERIOD) : period;
    c.high   = (high < cfg_word_t'(CLKDIV_MIN_HIGH)) ? cfg_word_t'(CLKDIV_MIN_HIGH) : high;
    if (c.high > c.period - cfg_word_t'(1)) begin
      c.high = c.period - cfg_word_t'(1);
    end
    return c;
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Configuration holder for clk_divider_prog: clamps requested settings, keeps them
// pending until the next period boundary and presents current and next config.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int          W          = 26,
  parameter int unsigned DEF_PERIOD = CLKDIV_DEF_PERIOD,
  parameter int unsigned DEF_HIGH   = CLKDIV_DEF_HIGH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en,
  input  logic         load,
  input  logic         wrap,
  input  logic [W-1:0] req_period,
  input  logic [W-1:0] req_high,
  output logic         busy,
  output logic         apply,
  output logic [W-1:0] period_r,
  output logic [W-1:0] high_r,
  output logic [W-1:0] period_nxt,
  output logic [W-1:0] high_nxt
);

  logic [W-1:0] clamp_period;
  logic [W-1:0] clamp_high;
  logic [W-1:0] pend_period;
  logic [W-1:0] pend_high;
  logic         load_now;

  // period occupies the upper half of the packed result
  assign clamp_period = W'(clamp_cfg(CLKDIV_CFG_W'(req_period), CLKDIV_CFG_W'(req_high)) >> CLKDIV_CFG_W);
  assign clamp_high   = W'(clamp_cfg(CLKDIV_CFG_W'(req_period), CLKDIV_CFG_W'(req_high)));

  assign load_now = load && (!en || wrap);
  assign apply    = load_now || (wrap && busy);

  always_comb begin
    period_nxt = period_r;
    high_nxt   = high_r;
    if (load_now) begin
      period_nxt = clamp_period;
      high_nxt   = clamp_high;
    end else if (wrap && busy) begin
      period_nxt = pend_period;
      high_nxt   = pend_high;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_r    <= W'(DEF_PERIOD);
      high_r      <= W'(DEF_HIGH);
      pend_period <= '0;
      pend_high   <= '0;
      busy        <= 1'b0;
    end else begin
      period_r <= period_nxt;
      high_r   <= high_nxt;
      if (load && !load_now) begin
        pend_period <= clamp_period;
        pend_high   <= clamp_high;
        busy        <= 1'b1;
      end else if (apply) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider and tick generator with glitch-free reconfiguration.
// Define CLKDIV_WRAP_EN to add the wrap_o period-boundary strobe.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int          W          = 26,
  parameter int unsigned DEF_PERIOD = CLKDIV_DEF_PERIOD,
  parameter int unsigned DEF_HIGH   = CLKDIV_DEF_HIGH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] period_i,
  input  logic [W-1:0] high_i,
  output logic         busy_o,
  output logic         clk_o,
  output logic         tick_o,
  output logic [W-1:0] cnt_o
`ifdef CLKDIV_WRAP_EN
  ,
  output logic         wrap_o
`endif
);

  logic [W-1:0] period_r;
  logic [W-1:0] high_r;
  logic [W-1:0] period_nxt;
  logic [W-1:0] high_nxt;
  logic [W-1:0] lo_r;
  logic [W-1:0] lo_nxt;
  logic [W-1:0] cnt_nxt;
  logic         wrap;
  logic         apply;

  clk_div_cfg #(
    .W          (W),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH)
  ) u_cfg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en         (en_i),
    .load       (load_i),
    .wrap       (wrap),
    .req_period (period_i),
    .req_high   (high_i),
    .busy       (busy_o),
    .apply      (apply),
    .period_r   (period_r),
    .high_r     (high_r),
    .period_nxt (period_nxt),
    .high_nxt   (high_nxt)
  );

  assign wrap   = en_i && (cnt_o == period_r - W'(1));
  assign lo_r   = period_r - high_r;
  assign lo_nxt = period_nxt - high_nxt;
  assign tick_o = en_i && (cnt_o == lo_r);

`ifdef CLKDIV_WRAP_EN
  assign wrap_o = wrap;
`endif

  always_comb begin
    cnt_nxt = cnt_o;
    if (wrap || apply) begin
      cnt_nxt = '0;
    end else if (en_i) begin
      cnt_nxt = cnt_o + W'(1);
    end
  end

  // clk_o is derived from the next count and next config so it is glitch-free
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
      clk_o <= 1'b0;
    end else begin
      cnt_o <= cnt_nxt;
      clk_o <= (cnt_nxt >= lo_nxt);
    end
  end

endmodule
